// File: rtl/sum_req_initiator.sv
// rtl/sum_req_initiator.sv - initiator side of the two-operand sum request/response interface
//
// Buffers single operands in a small FIFO, pairs consecutive operands into one
// (a, b) request, issues it over a valid/ready channel and waits for the
// single-beat response. Counts completed transactions and raises a sticky
// timeout flag when a response does not arrive in time.
//
// Optional build macro: SUM_REQ_INITIATOR_CHECK_EN adds the sticky `mismatch`
// output and a comparator of rsp_data against the truncated sum of the pair.
//
// Ports:
//   clk, rst                 clock; synchronous active-high reset
//   in_valid/in_ready/in_data operand stream into the FIFO
//   req_valid/req_ready       request handshake, carrying req_a/req_b
//   rsp_valid/rsp_data        single-beat response
//   busy                      FSM not in IDLE
//   timeout_err               sticky response-timeout flag (ERROR is terminal)
//   mismatch                  (optional) sticky wrong-sum flag
//   pair_count                completed transactions, wraps at 16 bits
module sum_req_initiator #(
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [DATA_WIDTH-1:0] req_a,
  output logic [DATA_WIDTH-1:0] req_b,
  input  logic                  rsp_valid,
  input  logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic                  timeout_err,
`ifdef SUM_REQ_INITIATOR_CHECK_EN
  output logic                  mismatch,
`endif
  output logic [15:0]           pair_count
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD_A   = 3'd1,
    LOAD_B   = 3'd2,
    SEND     = 3'd3,
    WAIT_RSP = 3'd4,
    ERROR    = 3'd5
  } state_t;

  state_t state, next_state;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic [TW-1:0]         timer;
  logic                  full, push, pop;
  logic                  rsp_accept;

  // in_ready comes from registered state only, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign full       = (count == CW'(FIFO_DEPTH));
  assign in_ready   = !rst && !full;
  assign push       = in_valid && in_ready;
  assign rsp_accept = (state == WAIT_RSP) && rsp_valid;

  assign req_valid  = (state == SEND);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    case (state)
      IDLE:     if (count >= CW'(2)) next_state = LOAD_A;
      LOAD_A: begin
        pop        = 1'b1;
        next_state = LOAD_B;
      end
      LOAD_B: begin
        pop        = 1'b1;
        next_state = SEND;
      end
      SEND:     if (req_ready) next_state = WAIT_RSP;
      // A response arriving on the final timer cycle still wins over timeout.
      WAIT_RSP: begin
        if (rsp_valid)                              next_state = IDLE;
        else if (timer == TW'(TIMEOUT_CYCLES - 1))  next_state = ERROR;
      end
      ERROR:    next_state = ERROR;
      default:  next_state = IDLE;
    endcase
  end

  // Storage array carries no reset; emptiness is defined by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      req_a       <= '0;
      req_b       <= '0;
      timer       <= '0;
      pair_count  <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (state == LOAD_A) req_a <= mem[rd_ptr];
      if (state == LOAD_B) req_b <= mem[rd_ptr];

      if (state == WAIT_RSP && !rsp_valid) timer <= timer + TW'(1);
      else                                 timer <= '0;

      if (rsp_accept) pair_count <= pair_count + 16'd1;

      if (state == WAIT_RSP && next_state == ERROR) timeout_err <= 1'b1;
    end
  end

`ifdef SUM_REQ_INITIATOR_CHECK_EN
  logic [DATA_WIDTH-1:0] exp_sum;
  assign exp_sum = req_a + req_b;

  always_ff @(posedge clk) begin
    if (rst)                                   mismatch <= 1'b0;
    else if (rsp_accept && rsp_data != exp_sum) mismatch <= 1'b1;
  end
`endif

endmodule
